// File: rtl/mul_add_pkg.sv
// Shared defaults for the shift-add multiplier-accumulator and its companion divider bench.
// Optional DONE pulse is controlled by MUL_ADD_DONE_EN (see mul_add.sv).
package mul_add_pkg;

    localparam int BW_MPLIER_DEF = 4;
    localparam int BW_MCAND_DEF  = 3;

    // Smallest counter width that can hold n-1; never narrower than one bit.
    function automatic int min_bw_cnt(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_add_if.sv
// Operand/result bundle for mul_add. DONE exists only when MUL_ADD_DONE_EN is defined.
interface mul_add_if
    import mul_add_pkg::*;
#(
    parameter int BW_MPLIER = BW_MPLIER_DEF,
    parameter int BW_MCAND  = BW_MCAND_DEF
);
    logic [BW_MCAND-1:0]           MCAND;
    logic [BW_MPLIER-1:0]          MPLIER;
    logic [BW_MCAND-1:0]           ADDEND;
    logic                          START;
    logic [BW_MPLIER+BW_MCAND-1:0] PROD;
    logic                          BUSY;
`ifdef MUL_ADD_DONE_EN
    logic                          DONE;

    modport master (output MCAND, MPLIER, ADDEND, START, input PROD, BUSY, DONE);
    modport slave  (input MCAND, MPLIER, ADDEND, START, output PROD, BUSY, DONE);
`else
    modport master (output MCAND, MPLIER, ADDEND, START, input PROD, BUSY);
    modport slave  (input MCAND, MPLIER, ADDEND, START, output PROD, BUSY);
`endif
endinterface

// File: rtl/mul_add_step.sv
// One shift-add iteration: conditionally add MCAND into the accumulator half, then shift right keeping the carry.
module mul_add_step
    import mul_add_pkg::*;
#(
    parameter int BW_MPLIER = BW_MPLIER_DEF,
    parameter int BW_MCAND  = BW_MCAND_DEF
) (
    input  logic [BW_MPLIER+BW_MCAND-1:0] src,
    input  logic [BW_MCAND-1:0]           mcand,
    output logic [BW_MPLIER+BW_MCAND-1:0] p_next
);
    localparam int BW_P = BW_MPLIER + BW_MCAND;

    logic [BW_MCAND:0] sum;

    assign sum = {1'b0, src[BW_P-1:BW_MPLIER]} + (src[0] ? {1'b0, mcand} : '0);

    // With a one-bit multiplier there are no remaining multiplier bits to shift down.
    if (BW_MPLIER == 1) begin : g_single
        assign p_next = sum;
    end else begin : g_multi
        assign p_next = {sum, src[BW_MPLIER-1:1]};
    end
endmodule

// File: rtl/mul_add.sv
// Sequential PROD = MPLIER*MCAND + ADDEND, one multiplier bit per clock, LSB first.
// Define MUL_ADD_DONE_EN to add a registered one-cycle DONE pulse on completion.
module mul_add
    import mul_add_pkg::*;
#(
    parameter int BW_MPLIER = BW_MPLIER_DEF,
    parameter int BW_MCAND  = BW_MCAND_DEF,
    parameter int BW_CNT    = min_bw_cnt(BW_MPLIER)
) (
    input  logic     CLK,
    input  logic     RSTX,
    mul_add_if.slave bus
);
    localparam int BW_P = BW_MPLIER + BW_MCAND;

    logic [BW_CNT-1:0] cnt;
    logic [BW_P-1:0]   p;
    logic [BW_P-1:0]   src;
    logic [BW_P-1:0]   p_next;
    logic              busy;

    assign busy = (cnt != '0);

    // A START, even mid-operation, restarts from fresh operands in the same cycle.
    assign src = bus.START ? {bus.ADDEND, bus.MPLIER} : p;

    mul_add_step #(
        .BW_MPLIER (BW_MPLIER),
        .BW_MCAND  (BW_MCAND)
    ) u_step (
        .src    (src),
        .mcand  (bus.MCAND),
        .p_next (p_next)
    );

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            cnt <= '0;
            p   <= '0;
        end else begin
            if (bus.START) begin
                cnt <= BW_CNT'(BW_MPLIER - 1);
            end else if (busy) begin
                cnt <= cnt - BW_CNT'(1);
            end
            if (bus.START || busy) begin
                p <= p_next;
            end
        end
    end

    assign bus.PROD = p;
    assign bus.BUSY = busy;

`ifdef MUL_ADD_DONE_EN
    logic done_q;

    // Fires on the last step of an operation; a restart on that edge suppresses it.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            done_q <= 1'b0;
        end else if (bus.START) begin
            done_q <= (BW_MPLIER == 1);
        end else begin
            done_q <= (cnt == BW_CNT'(1));
        end
    end

    assign bus.DONE = done_q;
`endif
endmodule

// File: tb/tb_mul_add.sv
// Self-checking bench for mul_add: vector table, random ops, restart/reset corners and a divider round trip.
module tb_mul_add;
    import mul_add_pkg::*;

    localparam int N = BW_MPLIER_DEF;
    localparam int M = BW_MCAND_DEF;

    logic clk;
    logic rstx;
    int   errors;
    int   checks;

    mul_add_if #(.BW_MPLIER(N), .BW_MCAND(M)) bus ();

    mul_add #(.BW_MPLIER(N), .BW_MCAND(M)) dut (
        .CLK  (clk),
        .RSTX (rstx),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mp;
        int mc;
        int ad;
        int exp;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int doneNow();
`ifdef MUL_ADD_DONE_EN
        return int'(bus.DONE);
`else
        return 0;
`endif
    endfunction

    function automatic int expDone();
`ifdef MUL_ADD_DONE_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Drives operands with START for one cycle; returns #1 after the sampling edge.
    task automatic applyStimulus(input int mp, input int mc, input int ad);
        bus.MPLIER = N'(mp);
        bus.MCAND  = M'(mc);
        bus.ADDEND = M'(ad);
        bus.START  = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
    endtask

    // Counts busy cycles and DONE pulses until idle, plus one trailing idle cycle.
    task automatic waitIdle(input string name, inout int nBusy, inout int nDone);
        for (int k = 0; k < 16 && bus.BUSY; k++) begin
            nBusy++;
            nDone += doneNow();
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_timeout"}, int'(bus.BUSY), 0);
        nDone += doneNow();
        @(posedge clk);
        #1;
        nDone += doneNow();
    endtask

    task automatic doOp(input string name, input int mp, input int mc, input int ad);
        int nBusy;
        int nDone;
        nBusy = 0;
        nDone = 0;
        applyStimulus(mp, mc, ad);
        waitIdle(name, nBusy, nDone);
        checkOutput({name, "_prod"}, int'(bus.PROD), mp * mc + ad);
        checkOutput({name, "_busycyc"}, nBusy, N - 1);
        checkOutput({name, "_done"}, nDone, expDone());
    endtask

    initial begin
        int nBusy;
        int nDone;
        int mp;
        int mc;
        int ad;
        errors = 0;
        checks = 0;
        rstx = 1'b0;
        bus.START  = 1'b0;
        bus.MPLIER = '0;
        bus.MCAND  = '0;
        bus.ADDEND = '0;

        vecs[0] = '{mp: 4,  mc: 3, ad: 1, exp: 13};
        vecs[1] = '{mp: 15, mc: 7, ad: 7, exp: 112};
        vecs[2] = '{mp: 0,  mc: 5, ad: 3, exp: 3};
        vecs[3] = '{mp: 1,  mc: 1, ad: 0, exp: 1};
        vecs[4] = '{mp: 7,  mc: 0, ad: 2, exp: 2};
        vecs[5] = '{mp: 8,  mc: 7, ad: 0, exp: 56};

        // Held in reset: START toggling must have no effect.
        bus.MPLIER = 4'd9;
        bus.MCAND  = 3'd5;
        bus.ADDEND = 3'd3;
        for (int i = 0; i < 4; i++) begin
            bus.START = ~bus.START;
            @(posedge clk);
            #1;
            checkOutput("reset_prod", int'(bus.PROD), 0);
            checkOutput("reset_busy", int'(bus.BUSY), 0);
            checkOutput("reset_done", doneNow(), 0);
        end
        bus.START = 1'b0;
        rstx = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            nBusy = 0;
            nDone = 0;
            applyStimulus(vecs[i].mp, vecs[i].mc, vecs[i].ad);
            waitIdle("vec", nBusy, nDone);
            checkOutput($sformatf("vec%0d_prod", i), int'(bus.PROD), vecs[i].exp);
            checkOutput($sformatf("vec%0d_busycyc", i), nBusy, N - 1);
            checkOutput($sformatf("vec%0d_done", i), nDone, expDone());
        end

        // Back-to-back: new START in the very first idle cycle.
        applyStimulus(3, 6, 2);
        while (bus.BUSY) begin
            @(posedge clk);
            #1;
        end
        doOp("b2b", 9, 4, 5);

        // Restart during the second busy cycle abandons (5,3,0).
        nBusy = 0;
        nDone = 0;
        applyStimulus(5, 3, 0);
        nBusy += int'(bus.BUSY);
        nDone += doneNow();
        @(posedge clk);
        #1;
        nBusy += int'(bus.BUSY);
        nDone += doneNow();
        applyStimulus(2, 7, 6);
        waitIdle("restart", nBusy, nDone);
        checkOutput("restart_prod", int'(bus.PROD), 20);
        checkOutput("restart_busycyc", nBusy, 2 + (N - 1));
        checkOutput("restart_done", nDone, expDone());

        // Asynchronous reset in the middle of an operation.
        applyStimulus(5, 3, 2);
        @(posedge clk);
        #1;
        checkOutput("midrst_busy_before", int'(bus.BUSY), 1);
        #2;
        rstx = 1'b0;
        #1;
        checkOutput("midrst_prod", int'(bus.PROD), 0);
        checkOutput("midrst_busy", int'(bus.BUSY), 0);
        checkOutput("midrst_done", doneNow(), 0);
        @(posedge clk);
        #1;
        rstx = 1'b1;
        doOp("after_rst", 1, 1, 0);

        for (int i = 0; i < 20; i++) begin
            mp = int'($urandom_range(15, 0));
            mc = int'($urandom_range(7, 0));
            ad = int'($urandom_range(7, 0));
            doOp($sformatf("rand%0d", i), mp, mc, ad);
        end

        // Divider round trip: QUOT*DIVISOR + REM must rebuild DIVIDEND.
        for (int dd = 0; dd < 16; dd++) begin
            for (int ds = 1; ds < 8; ds++) begin
                applyStimulus(dd / ds, ds, dd % ds);
                while (bus.BUSY) begin
                    @(posedge clk);
                    #1;
                end
                checkOutput($sformatf("rt_%0d_%0d", dd, ds), int'(bus.PROD), dd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end
endmodule

// File: doc/mul_add.md
# mul_add

Sequential shift-add multiplier-accumulator for the serdes datapath: computes PROD = MPLIER × MCAND + ADDEND at one multiplier bit per clock, LSB first. It is the inverse of the sequential divider. Feeding it QUOT, DIVISOR and REM reconstructs DIVIDEND, so the bench uses the pair for round-trip checking. Downstream, the serdes uses it to convert rate/ratio words back into absolute counts.

## Interface
- BW_CNT, 2, iteration counter width; must satisfy 2^BW_CNT > BW_MPLIER-1
- BW_MPLIER, 4, multiplier width (n)
- BW_MCAND, 3, multiplicand and addend width (m)
- RSTX  input  1  asynchronous reset, active-low
- CLK  input  1  clock, rising edge
- MCAND  input  BW_MCAND  multiplicand; sampled every busy cycle, must be held stable from START until BUSY falls
- MPLIER  input  BW_MPLIER  multiplier; sampled only in the START cycle
- ADDEND  input  BW_MCAND  addend; sampled only in the START cycle
- START  input  1  one-cycle request; also accepted while BUSY (restart)
- PROD  output  BW_MPLIER+BW_MCAND  result; valid when BUSY=0 after a START
- BUSY  output  1  iteration in progress
- DONE  output  1  completion pulse; present only with MUL_ADD_DONE_EN

## Operation
- State is a counter cnt (BW_CNT bits) and a shift register p (n+m bits): upper m bits are the accumulator, lower n bits are the remaining multiplier.
- BUSY = (cnt != 0). There is no other FSM state: idle means cnt=0, run means cnt≠0.
- Operand source: if START, use src = {ADDEND, MPLIER}; otherwise use src = p.
- Step, applied when START or BUSY:
  - sum = src[n+m-1:n] + (src[0] ? MCAND : 0), computed as m+1 bits.
  - p ← {sum, src[n-1:1]}, a right shift with the carry retained.
- Counter: START loads n-1. Otherwise BUSY decrements. Otherwise cnt holds 0.
- After n steps, p = MPLIER×MCAND + ADDEND exactly. Maximum value (2^n−1)(2^m−1)+(2^m−1) < 2^(n+m), so no overflow is possible and no saturation logic exists.
- PROD = p at all times. It holds the final value until the next START.
- START during BUSY: abandon the current operation and start a new one from the new operands in the same cycle.
- Idle without START: p holds and cnt stays 0.

## Timing
- Reset values: cnt=0, p=0, PROD=0, BUSY=0, DONE=0.
- START is sampled at edge E0, which performs step 1. Steps 2..n occur at edges E1..E(n-1).
- BUSY is high from after E0 until after E(n-1). PROD is valid after E(n-1).
- Latency is n edges. With defaults that is 4 edges, BUSY high 3 cycles.
- n=1: BUSY never asserts; PROD is valid after E0.
- Reset asserted mid-operation: everything clears immediately and asynchronously. The operation is lost and no DONE is produced.
- Back-to-back operation: START may be asserted in the first cycle with BUSY=0. There is no dead cycle.

## Configuration
- MUL_ADD_DONE_EN defined:
  - DONE is a registered one-cycle pulse, high in the cycle where BUSY has just fallen (cnt went 1→0), or one cycle after START when n=1.
  - A restart suppresses DONE for the abandoned operation.
- MUL_ADD_DONE_EN undefined: the DONE port and its flop are absent. Completion is detected from BUSY falling.

## Structure
- Shared package mul_add_pkg holds:
  - default widths (BW_MPLIER=4, BW_MCAND=3);
  - a clog2-based helper giving the minimum legal BW_CNT.
  - The divider bench imports the same defaults.
- One natural sub-module: mul_add_step, the combinational single iteration (src, MCAND → next p). The top level keeps the counter, the START mux and the registers.

## Test plan
- Reset with RSTX low, toggle START → PROD=0, BUSY=0, DONE=0 throughout.
- MPLIER=4, MCAND=3, ADDEND=1, START → BUSY high 3 cycles; PROD=13 after 4th edge; DONE pulses once (if enabled).
- Max operands MPLIER=15, MCAND=7, ADDEND=7 → PROD=112 (0x70), no wrap.
- Restart at 2nd busy cycle: first operation (5,3,0), second (2,7,6) → PROD=20, BUSY held continuously, exactly one DONE.
- RSTX pulsed low during busy cycle 2 → immediate PROD=0, BUSY=0. A following START (1,1,0) gives PROD=1.
- Round trip: exhaustive sweep of DIVIDEND 0..15, DIVISOR 1..7 through the divider, then mul_add(QUOT, DIVISOR, REM) → PROD == DIVIDEND in every case.
